// File: rtl/klp32_dbg_pkg.sv
// Shared types and default constants for the KLP32 execution-control (debug) logic.
package klp32_dbg_pkg;

  typedef enum logic [1:0] {
    PAUSED,
    RUN,
    STEP,
    HALTED
  } step_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int SYNC_STAGES_DEFAULT     = 2;

endpackage

// File: rtl/klp32_step_ctrl_if.sv
// Core-facing bundle of the step controller: board inputs, breakpoint compare, step outputs.
interface klp32_step_ctrl_if;
  logic        i_run_sw;
  logic        i_step_btn;
  logic        i_bp_en;
  logic [31:0] i_bp_addr;
  logic [31:0] i_pc;
  logic        o_step_en;
  logic        o_running;
  logic        o_bp_hit;
  logic [31:0] o_step_count;

  modport master (
    output i_run_sw, i_step_btn, i_bp_en, i_bp_addr, i_pc,
    input  o_step_en, o_running, o_bp_hit, o_step_count
  );

  modport slave (
    input  i_run_sw, i_step_btn, i_bp_en, i_bp_addr, i_pc,
    output o_step_en, o_running, o_bp_hit, o_step_count
  );
endinterface

// File: rtl/klp32_debounce.sv
// Synchronizer chain followed by a level debouncer for one asynchronous board input.
module klp32_debounce
  import klp32_dbg_pkg::*;
#(
    parameter logic RESET_VAL       = 1'b0,
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic rawIn,
    output logic level
);
    localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

    if (SYNC_STAGES < 2) begin : gSyncCheck
        $error("klp32_debounce: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : gDebCheck
        $error("klp32_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] syncQ;
    logic [CntW-1:0]        stableCnt;
    logic                   sampled;

    assign sampled = syncQ[SYNC_STAGES-1];

    // The counter tracks consecutive samples that disagree with the accepted level;
    // any sample matching the accepted level restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncQ     <= {SYNC_STAGES{RESET_VAL}};
            stableCnt <= '0;
            level     <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments so every flop in the chain samples the pre-edge value.
            syncQ <= {syncQ[SYNC_STAGES-2:0], rawIn};
            if (sampled == level) begin
                stableCnt <= '0;
            end else if (stableCnt == CntW'(DEBOUNCE_CYCLES - 1)) begin
                level     <= sampled;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + CntW'(1);
            end
        end
    end
endmodule

// File: rtl/klp32_step_ctrl.sv
// Execution-control stage: turns run switch, step button and PC breakpoint into a one-cycle step enable.
module klp32_step_ctrl
  import klp32_dbg_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int STEP_HZ         = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    klp32_step_ctrl_if.slave bus
);
    localparam int DIV  = CLK_HZ / STEP_HZ;
    localparam int DivW = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : gDivCheck
        $error("klp32_step_ctrl: CLK_HZ/STEP_HZ must be at least 2");
    end

    step_state_t     state;
    logic            runDb, btnDb, btnPrev, press;
    logic            bpArmed, bpMatch, tick, fire;
    logic [DivW-1:0] divCnt;
    logic            stepEn, running, bpHit;
    logic [31:0]     stepCount;

    klp32_debounce #(
        .RESET_VAL(1'b0), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uRunDb (
        .clk(clk), .reset(reset), .rawIn(bus.i_run_sw), .level(runDb)
    );

    klp32_debounce #(
        .RESET_VAL(1'b1), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uBtnDb (
        .clk(clk), .reset(reset), .rawIn(bus.i_step_btn), .level(btnDb)
    );

    // The button idles high, so a press is the debounced falling edge only.
    assign press   = btnPrev & ~btnDb;
    assign bpMatch = bus.i_bp_en & bpArmed & (bus.i_pc == bus.i_bp_addr);
    assign tick    = (divCnt == DivW'(DIV - 1));
    assign fire    = ((state == PAUSED) && !runDb && press) ||
                     ((state == HALTED) && press) ||
                     ((state == RUN) && !bpMatch && runDb && tick);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btnPrev <= 1'b1;
            bpArmed <= 1'b1;
        end else begin
            btnPrev <= btnDb;
            // Leaving the breakpoint PC re-arms; the halting PC itself never re-triggers.
            if (bus.i_pc != bus.i_bp_addr)
                bpArmed <= 1'b1;
            else if ((state == RUN) && bpMatch)
                bpArmed <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= PAUSED;
            stepEn    <= 1'b0;
            running   <= 1'b0;
            bpHit     <= 1'b0;
            divCnt    <= '0;
            stepCount <= '0;
        end else begin
            stepEn    <= fire;
            stepCount <= stepCount + {31'b0, fire};
            divCnt    <= '0;
            unique case (state)
                PAUSED: begin
                    if (runDb) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (press) begin
                        state <= STEP;
                    end
                end
                STEP: state <= PAUSED;
                RUN: begin
                    if (bpMatch) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        bpHit   <= 1'b1;
                    end else if (!runDb) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else begin
                        divCnt <= tick ? '0 : divCnt + DivW'(1);
                    end
                end
                HALTED: begin
                    if (press) begin
                        state <= STEP;
                        bpHit <= 1'b0;
                    end else if (!runDb) begin
                        state <= PAUSED;
                        bpHit <= 1'b0;
                    end
                end
                default: state <= PAUSED;
            endcase
        end
    end

    assign bus.o_step_en    = stepEn;
    assign bus.o_running    = running;
    assign bus.o_bp_hit     = bpHit;
    assign bus.o_step_count = stepCount;
endmodule
